// File: rtl/train_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : train_sequencer_if                                           |
// | Description : Control and layer-handshake bundle of the training run       |
// |               sequencer. The master side is the host/datapath, the slave   |
// |               side is the sequencer itself.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface train_sequencer_if #(
  parameter int LAYER_ADDR_WIDTH = 3,
  parameter int SAMPLE_ADDR_SIZE = 10,
  parameter int EPOCH_WIDTH      = 16
);
  logic                        start;
  logic                        abort;
  logic                        mode;
  logic [SAMPLE_ADDR_SIZE-1:0] num_samples;
  logic [EPOCH_WIDTH-1:0]      num_epochs;
  logic                        layer_done;
  logic                        layer_start;
  logic [LAYER_ADDR_WIDTH-1:0] layer;
  logic                        backward;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_addr;
  logic [EPOCH_WIDTH-1:0]      epoch;
  logic                        busy;
  logic                        done;
  logic                        aborted;

  modport master (
    output start, abort, mode, num_samples, num_epochs, layer_done,
    input  layer_start, layer, backward, sample_addr, epoch, busy, done, aborted
  );

  modport slave (
    input  start, abort, mode, num_samples, num_epochs, layer_done,
    output layer_start, layer, backward, sample_addr, epoch, busy, done, aborted
  );
endinterface
`default_nettype wire

// File: rtl/train_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : train_sequencer                                              |
// | Description : Run controller for the layer-multiplexed backprop engine.    |
// |               Iterates epochs x samples x layers, forward sweep then       |
// |               (train mode) backward sweep, via a start/done handshake.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module train_sequencer #(
  parameter int LAYER_ADDR_WIDTH = 3,
  parameter int LAYER_MAX        = 3,
  parameter int SAMPLE_ADDR_SIZE = 10,
  parameter int MAX_SAMPLES      = 1000,
  parameter int EPOCH_WIDTH      = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  train_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FWD_ISSUE   = 3'd1;
  localparam logic [2:0] S_FWD_WAIT    = 3'd2;
  localparam logic [2:0] S_BWD_ISSUE   = 3'd3;
  localparam logic [2:0] S_BWD_WAIT    = 3'd4;
  localparam logic [2:0] S_NEXT_SAMPLE = 3'd5;
  localparam logic [2:0] S_FINISH      = 3'd6;

  localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_CAP = SAMPLE_ADDR_SIZE'(MAX_SAMPLES);

  logic [2:0]                  state;
  logic [2:0]                  next_state;

  // Run parameters captured at start; all loop bounds compare against these.
  logic                        run_mode;
  logic [SAMPLE_ADDR_SIZE-1:0] run_samples;
  logic [EPOCH_WIDTH-1:0]      run_epochs;

  logic [LAYER_ADDR_WIDTH-1:0] layer_q;
  logic                        backward_q;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_q;
  logic [EPOCH_WIDTH-1:0]      epoch_q;
  logic                        done_q;
  logic                        aborted_q;

  logic [SAMPLE_ADDR_SIZE-1:0] clamped_samples;
  logic                        run_empty;
  logic                        abort_hit;
  logic [SAMPLE_ADDR_SIZE:0]   sample_inc;
  logic [EPOCH_WIDTH:0]        epoch_inc;
  logic                        more_samples;
  logic                        more_epochs;

  // One extra bit on the increments keeps "index+1 < count" free of wrap-around.
  assign clamped_samples = (bus.num_samples > SAMPLE_CAP) ? SAMPLE_CAP : bus.num_samples;
  assign run_empty       = (clamped_samples == '0) || (bus.num_epochs == '0);
  assign abort_hit       = (state != S_IDLE) && bus.abort;
  assign sample_inc      = {1'b0, sample_q} + (SAMPLE_ADDR_SIZE+1)'(1);
  assign epoch_inc       = {1'b0, epoch_q} + (EPOCH_WIDTH+1)'(1);
  assign more_samples    = sample_inc < {1'b0, run_samples};
  assign more_epochs     = epoch_inc < {1'b0, run_epochs};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state decode; abort outranks every other transition outside IDLE.
  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:        if (bus.start) next_state = run_empty ? S_FINISH : S_FWD_ISSUE;
        S_FWD_ISSUE:   next_state = S_FWD_WAIT;
        S_FWD_WAIT:    if (bus.layer_done) begin
                         if (layer_q < LAST_LAYER) next_state = S_FWD_ISSUE;
                         else if (!run_mode)       next_state = S_BWD_ISSUE;
                         else                      next_state = S_NEXT_SAMPLE;
                       end
        S_BWD_ISSUE:   next_state = S_BWD_WAIT;
        S_BWD_WAIT:    if (bus.layer_done) next_state = (layer_q != '0) ? S_BWD_ISSUE : S_NEXT_SAMPLE;
        S_NEXT_SAMPLE: next_state = (more_samples || more_epochs) ? S_FWD_ISSUE : S_FINISH;
        S_FINISH:      next_state = S_IDLE;
        default:       next_state = S_IDLE;
      endcase
    end
  end

  // Loop counters, latched run parameters and the registered done/aborted pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_mode    <= 1'b0;
      run_samples <= '0;
      run_epochs  <= '0;
      layer_q     <= '0;
      backward_q  <= 1'b0;
      sample_q    <= '0;
      epoch_q     <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_hit) begin
        aborted_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (bus.start) begin
            run_mode    <= bus.mode;
            run_samples <= clamped_samples;
            run_epochs  <= bus.num_epochs;
            layer_q     <= '0;
            backward_q  <= 1'b0;
            sample_q    <= '0;
            epoch_q     <= '0;
          end
          S_FWD_WAIT: if (bus.layer_done) begin
            if (layer_q < LAST_LAYER) layer_q    <= layer_q + LAYER_ADDR_WIDTH'(1);
            else if (!run_mode)       backward_q <= 1'b1;
          end
          S_BWD_WAIT: if (bus.layer_done && (layer_q != '0)) begin
            layer_q <= layer_q - LAYER_ADDR_WIDTH'(1);
          end
          S_NEXT_SAMPLE: begin
            layer_q    <= '0;
            backward_q <= 1'b0;
            if (more_samples) begin
              sample_q <= sample_inc[SAMPLE_ADDR_SIZE-1:0];
            end else begin
              sample_q <= '0;
              if (more_epochs) epoch_q <= epoch_inc[EPOCH_WIDTH-1:0];
            end
          end
          S_FINISH: done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Output decode: issue strobe and busy follow the state, the rest are registers.
  always_comb begin
    bus.layer_start = (state == S_FWD_ISSUE) || (state == S_BWD_ISSUE);
    bus.busy        = (state != S_IDLE);
    bus.layer       = layer_q;
    bus.backward    = backward_q;
    bus.sample_addr = sample_q;
    bus.epoch       = epoch_q;
    bus.done        = done_q;
    bus.aborted     = aborted_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_train_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_train_sequencer                                           |
// | Description : Self-checking bench for train_sequencer: randomized runs     |
// |               against an op-list reference model plus directed corners.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_train_sequencer;
  localparam int LAW  = 3;
  localparam int LMAX = 3;
  localparam int SAW  = 10;
  localparam int MAXS = 1000;
  localparam int EW   = 16;

  typedef struct { int ep; int smp; int lyr; int bwd; } op_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  train_sequencer_if #(.LAYER_ADDR_WIDTH(LAW), .SAMPLE_ADDR_SIZE(SAW), .EPOCH_WIDTH(EW)) bus ();

  train_sequencer #(
    .LAYER_ADDR_WIDTH(LAW), .LAYER_MAX(LMAX), .SAMPLE_ADDR_SIZE(SAW),
    .MAX_SAMPLES(MAXS), .EPOCH_WIDTH(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  busy_cnt = 0;
  int  fixed_delay = 1;
  int  max_delay   = 1;
  bit  noise_en    = 1'b0;
  int  done_cnt = 0, abort_cnt = 0, ls_cnt = 0, done_edge = 0, last_smp = -1;
  op_t exp_q[$];
  op_t cur;

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference op list: nested epoch/sample/layer loops straight from the run rules.
  task automatic build_expect(input bit m, input int ns, input int ne);
    int s;
    s = (ns > MAXS) ? MAXS : ns;
    exp_q.delete();
    for (int e = 0; e < ne; e++)
      for (int k = 0; k < s; k++) begin
        for (int l = 0; l < LMAX; l++) exp_q.push_back('{e, k, l, 0});
        if (!m) for (int l = LMAX - 1; l >= 0; l--) exp_q.push_back('{e, k, l, 1});
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_layer_start"}, bus.layer_start, 0);
    check_value({tag, "_layer"},       bus.layer, 0);
    check_value({tag, "_backward"},    bus.backward, 0);
    check_value({tag, "_sample_addr"}, bus.sample_addr, 0);
    check_value({tag, "_epoch"},       bus.epoch, 0);
    check_value({tag, "_busy"},        bus.busy, 0);
    check_value({tag, "_done"},        bus.done, 0);
    check_value({tag, "_aborted"},     bus.aborted, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Datapath responder and op monitor.
  initial begin
    bus.layer_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done)    begin done_cnt++; done_edge = cyc; end
      if (bus.aborted) abort_cnt++;
      if (!rst || !bus.busy) busy_cnt = 0;
      if (busy_cnt > 0) begin
        check_value("hold_layer",    bus.layer, cur.lyr);
        check_value("hold_backward", bus.backward, cur.bwd);
        check_value("hold_sample",   bus.sample_addr, cur.smp);
        busy_cnt--;
        bus.layer_done = (busy_cnt == 0);
      end else if (bus.layer_start) begin
        ls_cnt++;
        last_smp = bus.sample_addr;
        if (exp_q.size() == 0) begin
          check_value("unexpected_layer_start", bus.layer_start, 0);
          cur = '{bus.epoch, bus.sample_addr, bus.layer, bus.backward};
        end else begin
          cur = exp_q.pop_front();
          check_value("op_layer",    bus.layer, cur.lyr);
          check_value("op_backward", bus.backward, cur.bwd);
          check_value("op_sample",   bus.sample_addr, cur.smp);
          check_value("op_epoch",    bus.epoch, cur.ep);
        end
        busy_cnt = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, max_delay);
        bus.layer_done = noise_en;
      end else begin
        bus.layer_done = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic pulse_start(input bit m, input int ns, input int ne, output int start_edge);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.mode = m;
    bus.num_samples = SAW'(ns); bus.num_epochs = EW'(ne);
    bus.abort = 1'($urandom_range(0, 1));
    start_edge = cyc + 1;
    @(negedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.mode = 1'($urandom_range(0, 1));
    bus.num_samples = SAW'($urandom_range(0, 1023));
    bus.num_epochs  = EW'($urandom_range(0, 5));
  endtask

  // exp_lat < 0 skips the latency check (random handshake delays).
  task automatic run_case(input string name, input bit m, input int ns, input int ne,
                          input int fdel, input int mdel, input bit noise, input bit poke,
                          input int exp_lat);
    int s, n_ops, d0, a0, l0, se, budget;
    bit seen;
    s = (ns > MAXS) ? MAXS : ns;
    build_expect(m, ns, ne);
    n_ops = exp_q.size();
    fixed_delay = fdel; max_delay = mdel; noise_en = noise;
    d0 = done_cnt; a0 = abort_cnt; l0 = ls_cnt;
    budget = n_ops * (mdel + fdel + 2) + 50;
    pulse_start(m, ns, ne, se);
    check_value({name, "_busy_after_start"}, bus.busy, 1);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) seen = 1'b1;
      else if (poke && c == 7 && bus.busy) begin
        bus.start = 1'b1; bus.mode = ~m;
        bus.num_samples = SAW'($urandom_range(1, 9)); bus.num_epochs = EW'($urandom_range(1, 9));
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check_value({name, "_done_seen"}, seen, 1);
    if (seen && exp_lat >= 0) check_value({name, "_latency"}, done_edge - se, exp_lat);
    check_value({name, "_final_sample"}, bus.sample_addr, 0);
    check_value({name, "_final_epoch"},  bus.epoch, (s == 0 || ne == 0) ? 0 : ne - 1);
    check_value({name, "_busy_at_done"}, bus.busy, 0);
    check_value({name, "_ops_issued"},   ls_cnt - l0, n_ops);
    check_value({name, "_ops_missing"},  exp_q.size(), 0);
    @(negedge clk); #1;
    check_value({name, "_done_one_cycle"}, bus.done, 0);
    check_value({name, "_done_count"},  done_cnt - d0, 1);
    check_value({name, "_no_abort"},    abort_cnt - a0, 0);
    noise_en = 1'b0;
  endtask

  function automatic int latency(input bit m, input int ns, input int ne);
    int s;
    s = (ns > MAXS) ? MAXS : ns;
    if (s == 0 || ne == 0) return 1;
    return 1 + ne * s * (m ? 2 * LMAX + 1 : 4 * LMAX + 1);
  endfunction

  initial begin
    int se, d0, a0;
    bit hit;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.num_samples = '0; bus.num_epochs = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_case("train_basic", 1'b0, 2, 1, 1, 1, 1'b0, 1'b0, latency(1'b0, 2, 1));
    run_case("infer_epochs", 1'b1, 3, 2, 1, 1, 1'b1, 1'b0, latency(1'b1, 3, 2));
    run_case("zero_samples", 1'b0, 0, 3, 1, 1, 1'b1, 1'b0, latency(1'b0, 0, 3));
    run_case("zero_epochs",  1'b1, 2, 0, 1, 1, 1'b0, 1'b0, latency(1'b1, 2, 0));
    run_case("clamp", 1'b1, 1023, 1, 1, 1, 1'b0, 1'b0, latency(1'b1, 1023, 1));
    check_value("clamp_last_sample", last_smp, MAXS - 1);
    run_case("stall_poke", 1'b0, 1, 1, 6, 6, 1'b1, 1'b1, -1);

    // Asynchronous reset while a forward op is outstanding.
    build_expect(1'b0, 2, 1);
    fixed_delay = 3; d0 = done_cnt; a0 = abort_cnt;
    pulse_start(1'b0, 2, 1, se);
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (busy_cnt > 0 && !bus.layer_start && !bus.backward && bus.busy) hit = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check_value("rst_reached_fwd_wait", hit, 1);
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid_run");
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_value("rst_no_done",  done_cnt - d0, 0);
    check_value("rst_no_abort", abort_cnt - a0, 0);
    run_case("after_reset", 1'b0, 2, 2, 1, 1, 1'b0, 1'b0, latency(1'b0, 2, 2));

    // Abort in BWD_WAIT coinciding with layer_done, then abort held in IDLE.
    build_expect(1'b0, 2, 1);
    fixed_delay = 2; d0 = done_cnt; a0 = abort_cnt;
    pulse_start(1'b0, 2, 1, se);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk); #1;
      if (bus.layer_done && bus.backward && bus.busy && !bus.layer_start) begin
        hit = 1'b1;
        bus.abort = 1'b1;
        exp_q.delete();
      end
    end
    check_value("abort_reached_bwd_wait", hit, 1);
    @(negedge clk); #1;
    check_value("abort_pulse", bus.aborted, 1);
    check_value("abort_busy",  bus.busy, 0);
    check_value("abort_done",  bus.done, 0);
    repeat (10) @(negedge clk);
    #1;
    bus.abort = 1'b0;
    check_value("abort_once",    abort_cnt - a0, 1);
    check_value("abort_no_done", done_cnt - d0, 0);
    check_value("abort_idle",    bus.busy, 0);

    for (int r = 0; r < 8; r++)
      run_case("random", 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 3),
               0, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
- Parametrised run controller for the layer-multiplexed backprop engine.
- On a single `start` pulse it iterates epochs × samples × layers: a forward sweep through layers 0..LAYER_MAX-1, then, in training mode, a backward/update sweep through LAYER_MAX-1..0.
- It drives the shared layer datapath through a start/done handshake.
- Adds runtime sample/epoch counts, an inference-only mode, abort, and progress status.

Parameters:
- LAYER_ADDR_WIDTH, 3, width of layer index.
- LAYER_MAX, 3, number of layers; must be ≥1 and ≤ 2^LAYER_ADDR_WIDTH.
- SAMPLE_ADDR_SIZE, 10, width of sample address/count.
- MAX_SAMPLES, 1000, hard upper bound on samples per epoch; must be ≤ 2^SAMPLE_ADDR_SIZE-1.
- EPOCH_WIDTH, 16, width of epoch counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- abort  in  1  terminate the run; highest priority when not IDLE.
- mode  in  1  0 = train (fwd+bwd), 1 = inference (fwd only); latched at start.
- num_samples  in  SAMPLE_ADDR_SIZE  samples per epoch; latched at start.
- num_epochs  in  EPOCH_WIDTH  epochs to run; latched at start.
- layer_done  in  1  datapath completion pulse for the current layer op.
- layer_start  out  1  one-cycle pulse launching a layer op.
- layer  out  LAYER_ADDR_WIDTH  layer index of the current op.
- backward  out  1  0 = forward op, 1 = backward/update op.
- sample_addr  out  SAMPLE_ADDR_SIZE  current sample index.
- epoch  out  EPOCH_WIDTH  current epoch index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when a run is terminated by abort.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0: layer_start, layer, backward, sample_addr, epoch, busy, done, aborted.
  - Latched registers cleared.
  - Reset mid-run discards the run immediately; no done or aborted pulse is issued.
- States: IDLE, FWD_ISSUE, FWD_WAIT, BWD_ISSUE, BWD_WAIT, NEXT_SAMPLE, FINISH.
- IDLE:
  - On start=1: latch mode, num_epochs, and samples = min(num_samples, MAX_SAMPLES).
  - Set sample_addr=0, epoch=0, layer=0, backward=0.
  - If samples==0 or num_epochs==0, go to FINISH; otherwise go to FWD_ISSUE.
- FWD_ISSUE:
  - layer_start=1 for exactly this cycle; next state FWD_WAIT.
- FWD_WAIT:
  - Hold until layer_done=1.
  - If layer<LAYER_MAX-1: layer+1, go to FWD_ISSUE.
  - Else if mode=0: backward=1, layer unchanged (LAYER_MAX-1), go to BWD_ISSUE.
  - Else go to NEXT_SAMPLE.
- BWD_ISSUE:
  - layer_start=1 for exactly this cycle; next state BWD_WAIT.
- BWD_WAIT:
  - Hold until layer_done=1.
  - If layer>0: layer-1, go to BWD_ISSUE.
  - Else go to NEXT_SAMPLE.
- NEXT_SAMPLE (1 cycle):
  - layer=0, backward=0.
  - If sample_addr<samples-1: sample_addr+1, go to FWD_ISSUE.
  - Else sample_addr wraps to 0:
    - if epoch<num_epochs-1: epoch+1, go to FWD_ISSUE;
    - else go to FINISH.
- FINISH (1 cycle):
  - done=1, then IDLE.
  - sample_addr and epoch hold their final values until the next start.
- Handshake rules:
  - layer_done is sampled only in the *_WAIT states and is ignored elsewhere, including the ISSUE cycle.
  - Exactly one layer_start per completed layer_done.
  - layer, backward and sample_addr are stable from the ISSUE cycle until layer_done is accepted.
- abort:
  - In any non-IDLE state, abort=1 forces IDLE on the next edge.
  - aborted=1 for that one cycle; done is not asserted.
  - abort wins over a simultaneous layer_done or FINISH.
  - abort is ignored in IDLE.
- start while busy is ignored.
- start and abort asserted together in IDLE: the run starts (abort ignored).
- Latency and throughput:
  - start edge → first layer_start in the next cycle.
  - With layer_done returned one cycle after each layer_start:
    - per sample = 4·LAYER_MAX+1 cycles (train) or 2·LAYER_MAX+1 cycles (inference);
    - total = 1 + E·S·per_sample, then the FINISH cycle.
- Counters saturate-free: all comparisons use latched values; no arithmetic exceeds the declared widths.

Test Plan:
- Reset values: assert rst=0 mid-run while in FWD_WAIT → all outputs 0 immediately (async); no done or aborted pulse; a later start runs normally.
- Basic train run: LAYER_MAX=3, S=2, E=1, mode=0, layer_done one cycle after each layer_start →
  - 12 layer_start pulses;
  - layer/backward sequence 0f,1f,2f,2b,1b,0b per sample;
  - sample_addr 0 then 1;
  - done exactly 27 cycles after the start edge.
- Inference run with epochs: S=3, E=2, mode=1 →
  - 18 layer_start pulses, all with backward=0;
  - epoch increments to 1 after sample 2, and sample_addr wraps to 0;
  - done 1 cycle after the final NEXT_SAMPLE.
- Zero counts and clamping:
  - num_samples=0 → done one cycle after entering FINISH, with zero layer_start pulses;
  - num_samples=1023 with MAX_SAMPLES=1000 → last sample_addr is 999.
- Handshake robustness:
  - layer_done pulsed during ISSUE and during IDLE is ignored;
  - a 5-cycle stall in BWD_WAIT holds layer and backward stable;
  - start pulsed while busy has no effect.
- Abort: abort=1 in BWD_WAIT in the same cycle as layer_done → aborted pulse, state IDLE, busy=0, no done, no further layer_start.
